// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ==== pipeline_hazard_ctrl : PC/latch enable+flush sequencer, load-use FSM, perf counters ====
// ==== rev 1.0 ====

module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_pcsrc,
    input  logic             ex_MemtoReg,
    input  logic             ex_RegWr,
    input  logic [4:0]       ex_WrDest,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOADUSE = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic hazard;
    logic dmiss;
    logic src_match;
    logic flush_fire;
    logic stall_inc;

    // Only a load in EX can create a hazard; MEM/WB forwarding covers everything else.
    assign src_match = (ex_WrDest == id_rs) | (id_uses_rt & (ex_WrDest == id_rt));
    assign hazard    = ex_MemtoReg & ex_RegWr & (ex_WrDest != 5'd0) & src_match;
    assign dmiss     = (mem_dREN | mem_dWEN) & ~dhit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        flush_fire  = 1'b0;

        if (RST) begin
            state_next = RUN;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
        end else if ((state == HALT) || wb_halt) begin
            state_next = HALT;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
        end else if (dmiss) begin
            // WB holds too, so the frozen EX instruction keeps its forwarding source.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (mem_pcsrc) begin
            state_next  = RUN;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            flush_fire  = 1'b1;
        end else if ((state == RUN) && hazard) begin
            state_next = LOADUSE;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (state == LOADUSE) begin
            state_next = RUN;
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end else if (state != RUN) begin
            // Unused encoding recovers to RUN.
            state_next = RUN;
        end
    end

    assign halted    = (state == HALT);
    assign stall_inc = ~pc_en & (state != HALT) & ~wb_halt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (flush_fire && (flush_events != {CNT_W{1'b1}})) begin
                flush_events <= flush_events + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
